// File: rtl/rgbw_pkg.sv
// Shared constants for the RGBW scaling sequencer and its helpers.
package rgbw_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_STORE  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;
    localparam logic [1:0] CH_W = 2'd3;

    // Full intensity: the channel value passes through unscaled.
    localparam logic [7:0] LINT_FULL = 8'hFF;

endpackage

// File: rtl/rgbw_scale_sequencer_duty_round.sv
// Rounds a 16-bit product to its upper byte (half rounds up), saturating at 255.
module duty_round (
    input  logic [15:0] product,
    output logic [7:0]  duty
);

    logic [8:0] sum;

    // Add the half bit at 9 bits so a carry out becomes saturation.
    always_comb begin
        sum  = {1'b0, product[15:8]} + {8'd0, product[7]};
        duty = sum[8] ? 8'hFF : sum[7:0];
    end

endmodule

// File: rtl/rgbw_scale_sequencer.sv
// Scales R, G, B, W by the intensity byte through the shared multiplier and
// commits all four duties together on a PWM period boundary.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | operands on the multiplier bus, load strobe (or bypass write)
// WAIT   | waiting for mult_rdy, watchdog running
// STORE  | advance to next channel or go commit
// COMMIT | shadows complete, waiting for pwm_sync
module rgbw_scale_sequencer
    import rgbw_pkg::*;
#(
    parameter int WDT_MAX = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [7:0]  lint,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    input  logic [7:0]  white_in,
    output logic        mult_ld,
    output logic [7:0]  mult_a,
    output logic [7:0]  mult_b,
    input  logic [15:0] mult_res,
    input  logic        mult_rdy,
    input  logic        pwm_sync,
    output logic [7:0]  red_duty,
    output logic [7:0]  green_duty,
    output logic [7:0]  blue_duty,
    output logic [7:0]  white_duty,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int WDT_W = (WDT_MAX < 1) ? 1 : $clog2(WDT_MAX + 1);

    state_t           state, state_nxt;
    logic [7:0]       lint_q;
    logic [7:0]       chan_q   [4];
    logic [7:0]       shadow_q [4];
    logic [7:0]       duty_q   [4];
    logic [1:0]       ch_q;
    logic [WDT_W-1:0] wdt_q;
    logic             pending_q;
    logic             err_q;

    logic             snap, ch_inc, wdt_load, wdt_dec, abort, commit, ld;
    logic             shadow_wr;
    logic [7:0]       shadow_val;
    logic [7:0]       rounded;

    duty_round u_round (
        .product (mult_res),
        .duty    (rounded)
    );

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt  = state;
        snap       = 1'b0;
        ch_inc     = 1'b0;
        wdt_load   = 1'b0;
        wdt_dec    = 1'b0;
        abort      = 1'b0;
        commit     = 1'b0;
        ld         = 1'b0;
        shadow_wr  = 1'b0;
        shadow_val = 8'd0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    snap      = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (lint_q == LINT_FULL) begin
                    shadow_wr  = 1'b1;
                    shadow_val = chan_q[ch_q];
                    state_nxt  = S_STORE;
                end else begin
                    ld        = 1'b1;
                    wdt_load  = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mult_rdy) begin
                    shadow_wr  = 1'b1;
                    shadow_val = rounded;
                    state_nxt  = S_STORE;
                end else if (wdt_q <= WDT_W'(1)) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wdt_dec = 1'b1;
                end
            end
            S_STORE: begin
                if (ch_q == CH_W) begin
                    state_nxt = S_COMMIT;
                end else begin
                    ch_inc    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_COMMIT: begin
                if (pwm_sync) begin
                    commit = 1'b1;
                    if (pending_q || start) begin
                        snap      = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // Operand snapshot, channel index, watchdog, shadows, duties and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            lint_q    <= '0;
            ch_q      <= '0;
            wdt_q     <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                chan_q[i]   <= '0;
                shadow_q[i] <= '0;
                duty_q[i]   <= '0;
            end
        end else if (clk_en) begin
            if (snap) begin
                lint_q       <= lint;
                chan_q[CH_R] <= red_in;
                chan_q[CH_G] <= green_in;
                chan_q[CH_B] <= blue_in;
                chan_q[CH_W] <= white_in;
                ch_q         <= CH_R;
            end else if (ch_inc) begin
                ch_q <= ch_q + 2'd1;
            end

            if (wdt_load) begin
                wdt_q <= WDT_W'(WDT_MAX);
            end else if (wdt_dec) begin
                wdt_q <= wdt_q - WDT_W'(1);
            end

            if (abort) begin
                for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
            end else if (shadow_wr) begin
                shadow_q[ch_q] <= shadow_val;
            end

            if (commit) begin
                for (int i = 0; i < 4; i++) duty_q[i] <= shadow_q[i];
            end

            if (abort || commit) begin
                pending_q <= 1'b0;
            end else if (start && (state != S_IDLE)) begin
                pending_q <= 1'b1;
            end

            if (abort) begin
                err_q <= 1'b1;
            end else if (start) begin
                err_q <= 1'b0;
            end
        end
    end

    // Strobes are qualified by clk_en so a frozen LOAD/COMMIT does not stretch them.
    assign mult_ld    = ld & clk_en;
    assign done       = commit & clk_en;
    assign mult_a     = chan_q[ch_q];
    assign mult_b     = lint_q;
    assign busy       = (state != S_IDLE);
    assign err        = err_q;
    assign red_duty   = duty_q[CH_R];
    assign green_duty = duty_q[CH_G];
    assign blue_duty  = duty_q[CH_B];
    assign white_duty = duty_q[CH_W];

endmodule

// File: tb/tb_rgbw_scale_sequencer.sv
// Self-checking bench for rgbw_scale_sequencer with a 2-cycle multiplier model.
module tb_rgbw_scale_sequencer;

    localparam int WDT        = 63;
    localparam int PWM_PERIOD = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic        start = 1'b0;
    logic        pwm_sync = 1'b0;
    logic [7:0]  lint = '0, red_in = '0, green_in = '0, blue_in = '0, white_in = '0;
    logic        mult_ld, mult_rdy, busy, done, err;
    logic [7:0]  mult_a, mult_b;
    logic [15:0] mult_res;
    logic [7:0]  red_duty, green_duty, blue_duty, white_duty;

    int n_assert = 0;
    int n_fail = 0;
    int en_div = 1;
    int en_cnt = 0;
    int pcnt = 0;
    int ld_count = 0;
    int done_count = 0;
    bit mult_hang = 1'b0;
    int committed [4];

    logic        rdy1 = 1'b0, rdy2 = 1'b0;
    logic [15:0] res1 = '0, res2 = '0;

    rgbw_scale_sequencer #(.WDT_MAX(WDT)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .start      (start),
        .lint       (lint),
        .red_in     (red_in),
        .green_in   (green_in),
        .blue_in    (blue_in),
        .white_in   (white_in),
        .mult_ld    (mult_ld),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_res   (mult_res),
        .mult_rdy   (mult_rdy),
        .pwm_sync   (pwm_sync),
        .red_duty   (red_duty),
        .green_duty (green_duty),
        .blue_duty  (blue_duty),
        .white_duty (white_duty),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Prescaler enable and PWM boundary pulse, counted in enabled cycles.
    always @(posedge clk) begin
        #1;
        en_cnt++;
        clk_en = ((en_cnt % en_div) == 0);
        if (clk_en) pcnt++;
        pwm_sync = clk_en && ((pcnt % PWM_PERIOD) == 0);
    end

    // Multiplier: product valid two enabled cycles after the load strobe.
    always @(posedge clk) begin
        if (reset) begin
            rdy1 <= 1'b0; rdy2 <= 1'b0; res1 <= '0; res2 <= '0;
        end else if (clk_en) begin
            rdy1 <= mult_ld;
            res1 <= 16'(mult_a) * 16'(mult_b);
            rdy2 <= rdy1;
            res2 <= res1;
        end
    end
    assign mult_rdy = rdy2 && !mult_hang;
    assign mult_res = res2;

    function automatic logic [7:0] model_duty(input int c, input int l);
        int v;
        if (l == 255) return 8'(c);
        v = (c * l + 128) / 256;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Strobe alignment and commit-only duty changes, observed mid-cycle.
    logic [31:0] prev_duty = 'x;
    bit          prev_done = 1'b0;
    bit          edge_rst = 1'b1;
    always @(posedge clk) edge_rst = reset;
    always @(negedge clk) begin
        if (mult_ld === 1'b1) begin
            ld_count++;
            check("ld_on_enabled_cycle", clk_en, 1);
        end
        if (done === 1'b1) begin
            done_count++;
            check("done_with_pwm_sync", pwm_sync, 1);
            check("done_on_enabled_cycle", clk_en, 1);
        end
        if ({red_duty, green_duty, blue_duty, white_duty} !== prev_duty)
            check("duty_change_only_at_commit", 32'(prev_done || edge_rst), 1);
        prev_duty = {red_duty, green_duty, blue_duty, white_duty};
        prev_done = (done === 1'b1);
    end

    task automatic set_inputs(input int l, input int r, input int g, input int b, input int w);
        @(negedge clk);
        lint = 8'(l); red_in = 8'(r); green_in = 8'(g); blue_in = 8'(b); white_in = 8'(w);
    endtask

    task automatic do_start();
        int k = 0;
        @(negedge clk);
        while (!clk_en && k < 16) begin @(negedge clk); k++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin @(negedge clk); k++; end
        check({tag, "_done_within_budget"}, 32'(done), 1);
    endtask

    task automatic check_duties(input string tag, input int er, input int eg, input int eb, input int ew);
        check({tag, "_red"},   red_duty,   er);
        check({tag, "_green"}, green_duty, eg);
        check({tag, "_blue"},  blue_duty,  eb);
        check({tag, "_white"}, white_duty, ew);
        committed[0] = er; committed[1] = eg; committed[2] = eb; committed[3] = ew;
    endtask

    task automatic run_seq(input string tag, input int l, input int r, input int g, input int b, input int w);
        set_inputs(l, r, g, b, w);
        do_start();
        wait_done(tag, 2000);
        @(negedge clk);
        check_duties(tag, model_duty(r, l), model_duty(g, l), model_duty(b, l), model_duty(w, l));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base_ld, base_done, k, seen;
        int la, ra, ga, ba, wa, lb, rb, gb, bb, wb;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mult_ld", mult_ld, 0);
        check("rst_err", err, 0);
        check_duties("rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Nominal: intensity 128, ties round up
        set_inputs(128, 200, 100, 50, 255);
        base_ld = ld_count;
        do_start();
        check("ld_one_cycle_after_start", mult_ld, 1);
        check("ld_operand_a", mult_a, 200);
        check("ld_operand_b", mult_b, 128);
        check("busy_after_start", busy, 1);
        @(negedge clk);
        check("ld_single_cycle", mult_ld, 0);
        wait_done("plan", 2000);
        check("red_zero_before_commit", red_duty, 0);
        check("white_zero_before_commit", white_duty, 0);
        @(negedge clk);
        check_duties("plan", 100, 50, 25, 128);
        check("plan_ld_count", ld_count - base_ld, 4);
        check("plan_idle_after", busy, 0);

        // Bypass at full intensity
        set_inputs(255, 1, 2, 3, 255);
        base_ld = ld_count;
        do_start();
        wait_done("bypass", 2000);
        @(negedge clk);
        check_duties("bypass", 1, 2, 3, 255);
        check("bypass_no_ld", ld_count - base_ld, 0);

        // Random settings
        for (int i = 0; i < 4; i++)
            run_seq("rand", $urandom_range(0, 254), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255));

        // Watchdog abort with a silent multiplier
        mult_hang = 1'b1;
        base_done = done_count;
        set_inputs(77, 9, 8, 7, 6);
        do_start();
        check("wdt_ld_seen", mult_ld, 1);
        k = 0;
        while (err !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        // LOAD cycle plus WDT_MAX cycles in WAIT
        check("wdt_abort_latency", k, WDT + 1);
        check("wdt_err_set", err, 1);
        check("wdt_idle", busy, 0);
        repeat (5) @(negedge clk);
        check("wdt_err_sticky", err, 1);
        check("wdt_no_done", done_count - base_done, 0);
        check_duties("wdt_keep", committed[0], committed[1], committed[2], committed[3]);
        mult_hang = 1'b0;
        set_inputs(90, 250, 128, 3, 64);
        do_start();
        check("err_cleared_by_start", err, 0);
        wait_done("after_wdt", 2000);
        @(negedge clk);
        check_duties("after_wdt", model_duty(250, 90), model_duty(128, 90), model_duty(3, 90), model_duty(64, 90));

        // Pending start: three extra starts merge into one re-snapshotted sequence
        la = $urandom_range(1, 254); ra = $urandom_range(0, 255); ga = $urandom_range(0, 255);
        ba = $urandom_range(0, 255); wa = $urandom_range(0, 255);
        lb = $urandom_range(1, 254); rb = $urandom_range(0, 255); gb = $urandom_range(0, 255);
        bb = $urandom_range(0, 255); wb = $urandom_range(0, 255);
        base_done = done_count;
        set_inputs(la, ra, ga, ba, wa);
        do_start();
        repeat (3) do_start();
        set_inputs(lb, rb, gb, bb, wb);
        wait_done("pend_a", 2000);
        @(negedge clk);
        check_duties("pend_a", model_duty(ra, la), model_duty(ga, la), model_duty(ba, la), model_duty(wa, la));
        check("pend_restart_busy", busy, 1);
        wait_done("pend_b", 2000);
        @(negedge clk);
        check_duties("pend_b", model_duty(rb, lb), model_duty(gb, lb), model_duty(bb, lb), model_duty(wb, lb));
        repeat (150) @(negedge clk);
        check("pend_two_dones", done_count - base_done, 2);
        check("pend_idle_after", busy, 0);

        // Reset while waiting on channel 2
        set_inputs(100, 10, 20, 30, 40);
        do_start();
        seen = (mult_ld === 1'b1) ? 1 : 0;
        k = 0;
        while (seen < 3 && k < 100) begin
            @(negedge clk);
            k++;
            if (mult_ld === 1'b1) seen++;
        end
        check("rst_mid_reached_ch2", seen, 3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mult_ld", mult_ld, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_mult_b", mult_b, 0);
        check_duties("rst_mid", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        run_seq("after_rst", 200, 17, 0, 255, 129);

        // Prescaled clock: 1 enabled cycle in 4
        en_div = 4;
        set_inputs(128, 200, 100, 50, 255);
        do_start();
        wait_done("div4_plan", 4000);
        @(negedge clk);
        check_duties("div4_plan", 100, 50, 25, 128);
        for (int i = 0; i < 2; i++)
            run_seq("div4_rand", $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255));
        en_div = 1;
        run_seq("div1_again", 37, 255, 254, 1, 128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rgbw_scale_sequencer.md
# rgbw_scale_sequencer

Sequences the shared 8x8 multiplier to scale the four colour channels (red, green, blue, white) by the intensity byte. It takes the values latched by the SPI data dispenser and produces the four PWM duty bytes. Results collect in shadow registers and reach the duty outputs only on a PWM period boundary, so the lamp never shows a half-updated colour. It sits between the deserializer and the PWM generator, and owns the multiplier's load/ready handshake.

## Interface
Parameters:
- `WDT_MAX`, default 63: enabled cycles to wait for `mult_rdy` before aborting.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  prescaler enable from the clock divider. Every register updates only on `clk` edges where `clk_en`=1.
- `start`  in  1  new settings available (deserializer `rdy`); sampled on enabled cycles.
- `lint`  in  8  intensity.
- `red_in`, `green_in`, `blue_in`, `white_in`  in  8 each  raw channel values.
- `mult_ld`  out  1  multiplier load strobe.
- `mult_a`, `mult_b`  out  8 each  multiplier operands.
- `mult_res`  in  16  multiplier product.
- `mult_rdy`  in  1  product valid.
- `pwm_sync`  in  1  PWM period-boundary pulse.
- `red_duty`, `green_duty`, `blue_duty`, `white_duty`  out  8 each  committed duties.
- `busy`  out  1  sequence in progress (not IDLE).
- `done`  out  1  one-enabled-cycle pulse on commit.
- `err`  out  1  sticky watchdog abort flag; cleared by the next `start`.

## Operation
- States: IDLE, LOAD, WAIT, STORE, COMMIT.
- Channel order: R, G, B, W (2-bit index `ch`).
- **IDLE:** on `start`, snapshot `lint` and the four channel inputs into operand registers, set `ch`=0, and go to LOAD.
- **LOAD:** drive `mult_a` = the snapshotted channel and `mult_b` = the snapshotted `lint`; assert `mult_ld` for this cycle only; clear the watchdog; go to WAIT.
  - Bypass when `lint`=255: skip the multiplier, write the shadow register with the channel value directly, and go to STORE.
- **WAIT:** on `mult_rdy`, write `shadow[ch]` = rounded product; go to STORE.
  - The watchdog increments on each enabled cycle without `mult_rdy`.
  - When the watchdog reaches `WDT_MAX`: set `err`, discard the shadows, and go to IDLE. Outputs keep their old values.
- **Rounding rule:** duty = `mult_res[15:8]` + `mult_res[7]`, computed at 9 bits and saturated to 255.
  - With 8x8 operands the result never exceeds 254 unless the bypass path is taken.
- **STORE:** if `ch`=3, go to COMMIT; otherwise increment `ch` and go to LOAD.
- **COMMIT:** wait for `pwm_sync`. On the same enabled cycle, copy all four shadows to the duty outputs, pulse `done`, and go to IDLE. If a start is pending, go straight to LOAD with a fresh snapshot.
- **`start` while busy:** sets a one-deep pending flag. Further starts merge into it. The flag is consumed when COMMIT exits or when the watchdog aborts. Inputs are re-snapshotted when the pending sequence begins, not when `start` arrived.
- **`start` and `pwm_sync` together in COMMIT:** commit first, then restart.
- **Reset:** affects every state, including mid-sequence.
  - State returns to IDLE; all duties, operands, shadows, the pending flag and `err` go to 0.
  - `mult_ld`, `busy` and `done` go to 0.

## Timing
- All counts below are in enabled cycles.
- `start` at cycle n puts the FSM in LOAD at n+1, with `mult_ld` high at n+1.
- Multiplier latency is L (`mult_rdy` observed L cycles after `mult_ld`). Per channel the cost is 1 (LOAD) + L (WAIT) + 1 (STORE); the total for four channels is 4(L+2).
- Bypass path: 2 cycles per channel.
- Duty outputs change only on a `pwm_sync` cycle while in COMMIT.
- `done` is asserted in that same cycle.
- `mult_rdy` outside WAIT is ignored.
- `clk_en`=0 freezes everything, including the watchdog and the handling of the `done` pulse.

## Structure
- Shared package `rgbw_pkg` holds:
  - the state encoding localparams;
  - the channel index constants `CH_R`..`CH_W`;
  - the bypass intensity constant `LINT_FULL` = 8'hFF.
- Sub-module `duty_round` is combinational: 16-bit product in, saturated rounded byte out. It is shared with `colorGen` in the future.

## Test plan
- L=2 multiplier model, `clk_en`=1, `lint`=128, RGBW=200/100/50/255, `pwm_sync` every 40 cycles -> duties 100/50/25/128 (ties round up); `done` coincides with `pwm_sync`; outputs stay 0 before the commit.
- `lint`=255, RGBW=1/2/3/255 -> `mult_ld` never asserted; duties 1/2/3/255.
- Multiplier model never raises `mult_rdy`, `WDT_MAX`=63 -> `err`=1 after 63 WAIT cycles; duties unchanged from the previous commit; the next `start` clears `err`.
- Three `start` pulses during a sequence, then inputs changed -> exactly one extra sequence runs, using the new inputs; two `done` pulses in total.
- `reset` asserted in WAIT with channel 2 pending -> all outputs 0 on the next edge, FSM in IDLE; a later `start` completes normally.
- `clk_en` at 1-in-4 -> identical duty results; every `mult_ld` and `done` is aligned to an enabled cycle.
